wasm_locals_file: RTL and testbench

//  Per-call-frame local-variable store for the wasm core: serves get_local/set_local/tee_local.

---
 rtl/wasm_locals_pkg.sv | 40 ++++
 rtl/wasm_locals_ram.sv | 25 ++
 rtl/wasm_locals_file.sv | 192 +++++++++++++++++++
 tb/tb_wasm_locals_file.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/wasm_locals_pkg.sv
// Shared types for the wasm local-variable store: op codes, value types, trap codes, FSM states.
package wasm_locals_pkg;

  typedef enum logic [2:0] {
    OP_GET  = 3'd0,
    OP_SET  = 3'd1,
    OP_TEE  = 3'd2,
    OP_PUSH = 3'd3,
    OP_POP  = 3'd4
  } op_t;

  typedef enum logic [1:0] {
    VT_I32 = 2'd0,
    VT_I64 = 2'd1,
    VT_F32 = 2'd2,
    VT_F64 = 2'd3
  } val_type_t;

  typedef enum logic [3:0] {
    TRAP_NONE            = 4'd0,
    TRAP_NO_64B          = 4'd1,
    TRAP_INVALID_LOCAL   = 4'd2,
    TRAP_LOCALS_OVERFLOW = 4'd3,
    TRAP_FRAME_OVERFLOW  = 4'd4,
    TRAP_FRAME_UNDERFLOW = 4'd5
  } trap_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLEAR   = 2'd1,
    ST_TRAPPED = 2'd2
  } state_t;

  localparam int SLOT_W = 66;

  function automatic logic is_wide(input logic [1:0] t);
    return (t == VT_I64) || (t == VT_F64);
  endfunction

endpackage

// File: rtl/wasm_locals_ram.sv
// Slot storage: one synchronous write port and one registered read port, maps onto block RAM.
module wasm_locals_ram #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 66
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wasm_locals_file.sv
// Per-call-frame local store with frame push/pop, typed slots and sticky traps.
// Define LOCALS_ZERO_INIT_EN to zero every slot of a newly pushed frame before use.
module wasm_locals_file
  import wasm_locals_pkg::*;
#(
  parameter int LOCALS_DEPTH = 7,
  parameter int FRAME_DEPTH  = 3,
  parameter bit USE_64B      = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    op_valid_i,
  output logic                    op_ready_o,
  input  logic [2:0]              op_i,
  input  logic [LOCALS_DEPTH:0]   op_index_i,
  input  logic [LOCALS_DEPTH:0]   op_count_i,
  input  logic [63:0]             wr_data_i,
  input  logic [1:0]              wr_type_i,
  output logic                    rd_valid_o,
  output logic [63:0]             rd_data_o,
  output logic [1:0]              rd_type_o,
  output logic [3:0]              trap_o,
  output logic [FRAME_DEPTH:0]    frame_level_o
);

  localparam int LW = LOCALS_DEPTH + 1;
  localparam int AW = LOCALS_DEPTH + 2;
  localparam int NF = 2**FRAME_DEPTH;
  localparam int NS = 2**LOCALS_DEPTH;

  state_t                state_q, state_d;
  trap_t                 trap_q, trap_d, trap_code;
  logic [LW-1:0]         base_q, base_d, size_q, size_d, clr_cnt_q, clr_cnt_d;
  logic [FRAME_DEPTH:0]  level_q, level_d;
  logic                  rd_valid_q, rd_valid_d, rd_is_get_q, rd_is_get_d;
  logic [SLOT_W-1:0]     rd_hold_q, rd_hold_d;
  logic [LW-1:0]         stk_base_q [NF];
  logic [LW-1:0]         stk_size_q [NF];
  logic                  push_en;

  logic                    ram_we, ram_re;
  logic [LOCALS_DEPTH-1:0] ram_waddr, slot_addr;
  logic [SLOT_W-1:0]       ram_wdata, ram_rdata;
  logic [AW-1:0]           push_need;
  logic [FRAME_DEPTH-1:0]  pop_idx;

  assign slot_addr = LOCALS_DEPTH'(base_q + op_index_i);
  assign push_need = AW'(base_q) + AW'(size_q) + AW'(op_count_i);
  assign pop_idx   = FRAME_DEPTH'(level_q - 1'b1);

  always_comb begin
    state_d     = state_q;
    trap_d      = trap_q;
    base_d      = base_q;
    size_d      = size_q;
    level_d     = level_q;
    clr_cnt_d   = clr_cnt_q;
    rd_valid_d  = 1'b0;
    rd_is_get_d = rd_is_get_q;
    rd_hold_d   = rd_hold_q;
    push_en     = 1'b0;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_waddr   = slot_addr;
    ram_wdata   = {wr_type_i, wr_data_i};
    trap_code   = TRAP_NONE;
    op_ready_o  = (state_q == ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (op_valid_i) begin
          case (op_i)
            OP_GET: begin
              if (op_index_i >= size_q) trap_code = TRAP_INVALID_LOCAL;
              else begin
                ram_re      = 1'b1;
                rd_valid_d  = 1'b1;
                rd_is_get_d = 1'b1;
              end
            end
            OP_SET, OP_TEE: begin
              if (op_index_i >= size_q) trap_code = TRAP_INVALID_LOCAL;
              else if (!USE_64B && is_wide(wr_type_i)) trap_code = TRAP_NO_64B;
              else begin
                ram_we = 1'b1;
                if (op_i == OP_TEE) begin
                  rd_valid_d  = 1'b1;
                  rd_is_get_d = 1'b0;
                  rd_hold_d   = {wr_type_i, wr_data_i};
                end
              end
            end
            OP_PUSH: begin
              if (level_q == (FRAME_DEPTH+1)'(NF-1)) trap_code = TRAP_FRAME_OVERFLOW;
              else if (push_need > AW'(NS)) trap_code = TRAP_LOCALS_OVERFLOW;
              else begin
                push_en = 1'b1;
                base_d  = base_q + size_q;
                size_d  = op_count_i;
                level_d = level_q + 1'b1;
`ifdef LOCALS_ZERO_INIT_EN
                if (op_count_i != '0) begin
                  state_d   = ST_CLEAR;
                  clr_cnt_d = '0;
                end
`endif
              end
            end
            OP_POP: begin
              if (level_q == '0) trap_code = TRAP_FRAME_UNDERFLOW;
              else begin
                base_d  = stk_base_q[pop_idx];
                size_d  = stk_size_q[pop_idx];
                level_d = level_q - 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      ST_CLEAR: begin
        // base/size already describe the new frame; sweep it one slot per cycle
        ram_we    = 1'b1;
        ram_waddr = LOCALS_DEPTH'(base_q + clr_cnt_q);
        ram_wdata = {VT_I32, 64'd0};
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_d == size_q) state_d = ST_IDLE;
      end
      ST_TRAPPED: ;
      default: state_d = ST_IDLE;
    endcase

    if (trap_code != TRAP_NONE) begin
      trap_d  = trap_code;
      state_d = ST_TRAPPED;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      trap_q      <= TRAP_NONE;
      base_q      <= '0;
      size_q      <= '0;
      level_q     <= '0;
      clr_cnt_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_is_get_q <= 1'b0;
      rd_hold_q   <= '0;
    end else begin
      state_q     <= state_d;
      trap_q      <= trap_d;
      base_q      <= base_d;
      size_q      <= size_d;
      level_q     <= level_d;
      clr_cnt_q   <= clr_cnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_is_get_q <= rd_is_get_d;
      rd_hold_q   <= rd_hold_d;
    end
  end

  for (genvar gi = 0; gi < NF; gi++) begin : g_frame
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        stk_base_q[gi] <= '0;
        stk_size_q[gi] <= '0;
      end else if (push_en && level_q == (FRAME_DEPTH+1)'(gi)) begin
        stk_base_q[gi] <= base_q;
        stk_size_q[gi] <= size_q;
      end
    end
  end

  wasm_locals_ram #(.ADDR_W(LOCALS_DEPTH), .DATA_W(SLOT_W)) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (slot_addr),
    .rdata_o (ram_rdata)
  );

  // GET results come straight from the RAM register, which only reloads on the next GET
  assign rd_valid_o    = rd_valid_q;
  assign rd_data_o     = rd_is_get_q ? ram_rdata[63:0]  : rd_hold_q[63:0];
  assign rd_type_o     = rd_is_get_q ? ram_rdata[65:64] : rd_hold_q[65:64];
  assign trap_o        = trap_q;
  assign frame_level_o = level_q;

endmodule

// File: tb/tb_wasm_locals_file.sv
// Directed bench for wasm_locals_file; a second instance is built with 64-bit values disabled.
module tb_wasm_locals_file;
  import wasm_locals_pkg::*;

`ifdef LOCALS_ZERO_INIT_EN
  localparam bit ZI = 1'b1;
`else
  localparam bit ZI = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  op = '0;
  logic [7:0]  op_index = '0, op_count = '0;
  logic [63:0] wr_data = '0;
  logic [1:0]  wr_type = '0;

  logic        op_ready_a, rd_valid_a, op_ready_b, rd_valid_b;
  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_type_a, rd_type_b;
  logic [3:0]  trap_a, trap_b, level_a, level_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wasm_locals_file dut (
    .clk_i(clk), .reset_i(reset), .op_valid_i(op_valid), .op_ready_o(op_ready_a),
    .op_i(op), .op_index_i(op_index), .op_count_i(op_count), .wr_data_i(wr_data),
    .wr_type_i(wr_type), .rd_valid_o(rd_valid_a), .rd_data_o(rd_data_a),
    .rd_type_o(rd_type_a), .trap_o(trap_a), .frame_level_o(level_a)
  );

  wasm_locals_file #(.USE_64B(1'b0)) dut_n64 (
    .clk_i(clk), .reset_i(reset), .op_valid_i(op_valid), .op_ready_o(op_ready_b),
    .op_i(op), .op_index_i(op_index), .op_count_i(op_count), .wr_data_i(wr_data),
    .wr_type_i(wr_type), .rd_valid_o(rd_valid_b), .rd_data_o(rd_data_b),
    .rd_type_o(rd_type_b), .trap_o(trap_b), .frame_level_o(level_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    op_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic issue(input logic [2:0] o, input int arg, input logic [63:0] d, input logic [1:0] t);
    @(negedge clk);
    op = o; op_index = 8'(arg); op_count = 8'(arg);
    wr_data = d; wr_type = t; op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    $display("op=%0d arg=%0d data=%0h type=%0d -> rd_valid=%0b rd_data=%0h trap=%0d/%0d level=%0d",
             o, arg, d, t, rd_valid_a, rd_data_a, trap_a, trap_b, level_a);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!op_ready_a && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("wait_ready", 64'(op_ready_a), 64'd1);
  endtask

  task automatic push(input int cnt);
    issue(OP_PUSH, cnt, 64'd0, VT_I32);
    wait_ready();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int lowc;
    do_reset();
    check_eq("rst_ready", 64'(op_ready_a), 64'd1);
    check_eq("rst_rdv",   64'(rd_valid_a), 64'd0);
    check_eq("rst_data",  rd_data_a,       64'd0);
    check_eq("rst_type",  64'(rd_type_a),  64'd0);
    check_eq("rst_trap",  64'(trap_a),     64'd0);
    check_eq("rst_level", 64'(level_a),    64'd0);

    // 1: PUSH 4, SET/GET an i64
    push(4);
    check_eq("t1_level", 64'(level_a), 64'd1);
    issue(OP_SET, 2, 64'd3, VT_I64);
    check_eq("t1_set_rdv", 64'(rd_valid_a), 64'd0);
    issue(OP_GET, 2, 64'd0, VT_I32);
    check_eq("t1_rdv",  64'(rd_valid_a), 64'd1);
    check_eq("t1_data", rd_data_a,       64'd3);
    check_eq("t1_type", 64'(rd_type_a),  64'(VT_I64));
    check_eq("t1_trap", 64'(trap_a),     64'd0);

    // 2: TEE then GET the same slot on the following cycle
    issue(OP_TEE, 0, 64'd7, VT_I32);
    check_eq("t2_tee_rdv",  64'(rd_valid_a), 64'd1);
    check_eq("t2_tee_data", rd_data_a,       64'd7);
    issue(OP_GET, 0, 64'd0, VT_F64);
    check_eq("t2_get_data", rd_data_a,       64'd7);
    check_eq("t2_get_type", 64'(rd_type_a),  64'(VT_I32));

    // 3: index == size traps, trapped core ignores ops
    issue(OP_GET, 4, 64'd0, VT_I32);
    check_eq("t3_trap",  64'(trap_a),     64'd2);
    check_eq("t3_ready", 64'(op_ready_a), 64'd0);
    check_eq("t3_rdv",   64'(rd_valid_a), 64'd0);
    issue(OP_POP, 0, 64'd0, VT_I32);
    check_eq("t3_ign_level", 64'(level_a), 64'd1);
    check_eq("t3_ign_trap",  64'(trap_a),  64'd2);
    do_reset();
    check_eq("t3_rst_trap",  64'(trap_a),     64'd0);
    check_eq("t3_rst_ready", 64'(op_ready_a), 64'd1);
    issue(OP_GET, 0, 64'd0, VT_I32);
    check_eq("lvl0_get_trap", 64'(trap_a), 64'd2);

    // 4: nested frames restore outer locals, then underflow
    do_reset();
    push(2);
    issue(OP_SET, 0, 64'd9, VT_I32);
    push(2);
    issue(OP_SET, 0, 64'd5, VT_I32);
    issue(OP_GET, 0, 64'd0, VT_I32);
    check_eq("t4_inner", rd_data_a, 64'd5);
    issue(OP_POP, 0, 64'd0, VT_I32);
    check_eq("t4_level1", 64'(level_a), 64'd1);
    issue(OP_GET, 0, 64'd0, VT_I32);
    check_eq("t4_outer", rd_data_a, 64'd9);
    issue(OP_POP, 0, 64'd0, VT_I32);
    check_eq("t4_level0", 64'(level_a), 64'd0);
    issue(OP_POP, 0, 64'd0, VT_I32);
    check_eq("t4_underflow", 64'(trap_a), 64'd5);

    // frame-depth limit: level 7 is the deepest frame
    do_reset();
    for (int i = 0; i < 7; i++) push(0);
    check_eq("fo_level7", 64'(level_a), 64'd7);
    issue(OP_PUSH, 0, 64'd0, VT_I32);
    check_eq("fo_trap",  64'(trap_a),  64'd4);
    check_eq("fo_level", 64'(level_a), 64'd7);

    // 5: no-64-bit instance traps on i64 writes and leaves the slot alone
    do_reset();
    push(1);
    issue(OP_SET, 0, 64'h11, VT_I32);
    issue(OP_SET, 0, 64'h22, VT_I64);
    check_eq("t5_n64_trap",  64'(trap_b),     64'd1);
    check_eq("t5_n64_ready", 64'(op_ready_b), 64'd0);
    check_eq("t5_w64_trap",  64'(trap_a),     64'd0);
    issue(OP_GET, 0, 64'd0, VT_I32);
    check_eq("t5_w64_data", rd_data_a, 64'h22);
    do_reset();
    push(1);
    issue(OP_GET, 0, 64'd0, VT_I32);
    check_eq("t5_n64_slot", rd_data_b, ZI ? 64'd0 : 64'h11);
    check_eq("t5_n64_type", 64'(rd_type_b), 64'(VT_I32));

    do_reset();
    push(100);
    issue(OP_PUSH, 40, 64'd0, VT_I32);
    check_eq("t5_lov_trap", 64'(trap_a), 64'd3);
    do_reset();
    push(100);
    push(28);
    check_eq("t5_exact_trap", 64'(trap_a), 64'd0);
    push(0);
    check_eq("t5_empty_level", 64'(level_a), 64'd3);
    issue(OP_PUSH, 1, 64'd0, VT_I32);
    check_eq("t5_edge_trap", 64'(trap_a), 64'd3);

    // 6: re-pushed frame over dirty slots
    do_reset();
    push(3);
    for (int i = 0; i < 3; i++) issue(OP_SET, i, 64'hA0 + 64'(i), VT_F32);
    issue(OP_POP, 0, 64'd0, VT_I32);
    issue(OP_PUSH, 3, 64'd0, VT_I32);
    lowc = 0;
    while (!op_ready_a && lowc < 20) begin
      lowc++;
      @(posedge clk);
      #1;
    end
    check_eq("t6_clear_cycles", 64'(lowc), ZI ? 64'd3 : 64'd0);
    for (int i = 0; i < 3; i++) begin
      issue(OP_GET, i, 64'd0, VT_I32);
      check_eq("t6_data", rd_data_a, ZI ? 64'd0 : 64'hA0 + 64'(i));
      check_eq("t6_type", 64'(rd_type_a), ZI ? 64'(VT_I32) : 64'(VT_F32));
    end

`ifdef LOCALS_ZERO_INIT_EN
    issue(OP_PUSH, 5, 64'd0, VT_I32);
    @(posedge clk);
    #1;
    check_eq("t6_in_clear", 64'(op_ready_a), 64'd0);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check_eq("t6_abort_ready", 64'(op_ready_a), 64'd1);
    check_eq("t6_abort_level", 64'(level_a),    64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
